// File: rtl/bram_sdp_stream_reader.sv
// Burst read sequencer for a simple-dual-port BRAM read port: issues credit-limited reads,
// realigns DO through a latency pipe and re-streams the words as valid/ready with LAST.
module bram_sdp_stream_reader #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  CMD_VALID,
   output logic                  CMD_READY,
   input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
   input  logic [ADDR_WIDTH:0]   CMD_LEN,
   output logic [ADDR_WIDTH-1:0] RDADDR,
   output logic                  RDEN,
   input  logic [DATA_WIDTH-1:0] DO,
   output logic                  M_VALID,
   input  logic                  M_READY,
   output logic [DATA_WIDTH-1:0] M_DATA,
   output logic                  M_LAST,
   output logic                  BUSY
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + RD_LATENCY + 2) + 1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
   localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
   localparam logic [PW-1:0]         PTR_ONE  = 1;
   localparam logic [PW:0]           CNT_ONE  = 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   state_t                  state_q, state_d;
   logic                    cmd_ready_q, cmd_ready_d;
   logic [ADDR_WIDTH-1:0]   next_addr_q, next_addr_d;
   logic [ADDR_WIDTH-1:0]   rdaddr_q, rdaddr_d;
   logic [ADDR_WIDTH:0]     rem_q, rem_d;
   logic                    rden_q, rden_d;
   logic                    rdlast_q, rdlast_d;
   logic [RD_LATENCY-1:0]   pipe_vld_q, pipe_vld_d;
   logic [RD_LATENCY-1:0]   pipe_last_q, pipe_last_d;
   logic [DATA_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]   fifo_data_d [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]   fifo_last_q, fifo_last_d;
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [PW:0]             count_q, count_d;

   logic                    accept;
   logic                    push;
   logic                    pop;
   logic                    issue;
   logic [CW-1:0]           occupancy;

   // Occupancy counts every word already owed to the FIFO: buffered, on RDEN, and in the pipe.
   always_comb begin
      accept    = CMD_VALID && cmd_ready_q;
      pop       = (count_q != '0) && M_READY;
      push      = pipe_vld_q[RD_LATENCY-1];
      occupancy = CW'(count_q) + CW'(rden_q) + CW'($countones(pipe_vld_q));
      issue     = (state_q == S_ISSUE) && ((occupancy - CW'(pop)) < CW'(FIFO_DEPTH));
   end

   always_comb begin
      state_d     = state_q;
      next_addr_d = next_addr_q;
      rem_d       = rem_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               next_addr_d = CMD_ADDR;
               rem_d       = CMD_LEN;
               if (CMD_LEN != '0) state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (issue) begin
               next_addr_d = next_addr_q + ADDR_ONE;
               rem_d       = rem_q - LEN_ONE;
               if (rem_q == LEN_ONE) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pop && fifo_last_q[rd_ptr_q]) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      cmd_ready_d = (state_d == S_IDLE);
      rden_d      = issue;
      rdlast_d    = issue && (rem_q == LEN_ONE);
      rdaddr_d    = issue ? next_addr_q : rdaddr_q;
   end

   // Pipe stage 0 marks the edge that sampled RDEN; the last stage lines up with valid DO.
   always_comb begin
      pipe_vld_d     = '0;
      pipe_last_d    = '0;
      pipe_vld_d[0]  = rden_q;
      pipe_last_d[0] = rdlast_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
         pipe_vld_d[i]  = pipe_vld_q[i-1];
         pipe_last_d[i] = pipe_last_q[i-1];
      end
   end

   always_comb begin
      fifo_data_d = fifo_data_q;
      fifo_last_d = fifo_last_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      if (push) begin
         fifo_data_d[wr_ptr_q] = DO;
         fifo_last_d[wr_ptr_q] = pipe_last_q[RD_LATENCY-1];
         wr_ptr_d              = wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= S_IDLE;
         cmd_ready_q <= 1'b0;
         next_addr_q <= '0;
         rdaddr_q    <= '0;
         rem_q       <= '0;
         rden_q      <= 1'b0;
         rdlast_q    <= 1'b0;
         pipe_vld_q  <= '0;
         pipe_last_q <= '0;
         fifo_data_q <= '{default: '0};
         fifo_last_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         next_addr_q <= next_addr_d;
         rdaddr_q    <= rdaddr_d;
         rem_q       <= rem_d;
         rden_q      <= rden_d;
         rdlast_q    <= rdlast_d;
         pipe_vld_q  <= pipe_vld_d;
         pipe_last_q <= pipe_last_d;
         fifo_data_q <= fifo_data_d;
         fifo_last_q <= fifo_last_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   assign CMD_READY = cmd_ready_q;
   assign RDADDR    = rdaddr_q;
   assign RDEN      = rden_q;
   assign M_VALID   = (count_q != '0);
   assign M_DATA    = fifo_data_q[rd_ptr_q];
   assign M_LAST    = M_VALID && fifo_last_q[rd_ptr_q];
   assign BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_bram_sdp_stream_reader.sv
// Directed bench for bram_sdp_stream_reader: one instance at RD_LATENCY=1 and one at
// RD_LATENCY=2 share stimulus; each has its own BRAM model and stream scoreboard.
module tb_bram_sdp_stream_reader;

   typedef struct {
      logic [8:0] addr;
      logic [9:0] len;
      int         mode;       // 0: M_READY low, 1: high, 2: random
      int         words;
      logic [8:0] last_addr;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [8:0]  cmd_addr = '0;
   logic [9:0]  cmd_len = '0;
   logic        m_ready = 1'b0;
   logic        cmd_ready [2];
   logic        rden [2];
   logic [8:0]  rdaddr [2];
   logic        m_valid [2];
   logic [31:0] m_data [2];
   logic        m_last [2];
   logic        busy [2];
   logic [31:0] d1_s1 = '0;
   logic [31:0] d2_s1 = '0;
   logic [31:0] d2_s2 = '0;

   int          cyc = 0;
   int          rmode = 1;
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;
   int          cur_len = 0;
   logic [8:0]  exp_addr [2];
   int          got [2];
   int          last_cnt [2];
   logic [8:0]  last_addr [2];
   int          rden_cnt [2];
   int          vld_cnt [2];
   int          first_v [2];
   int          last_hs [2];
   logic        pv [2];
   logic        pr [2];
   logic        pl [2];
   logic [31:0] pd [2];
   vec_t        vecs [7];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bram_sdp_stream_reader #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .RD_LATENCY(1), .FIFO_DEPTH(4)) u_dut_l1 (
      .CLK(clk), .RST_N(rst_n), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready[0]),
      .CMD_ADDR(cmd_addr), .CMD_LEN(cmd_len), .RDADDR(rdaddr[0]), .RDEN(rden[0]),
      .DO(d1_s1), .M_VALID(m_valid[0]), .M_READY(m_ready), .M_DATA(m_data[0]),
      .M_LAST(m_last[0]), .BUSY(busy[0]));

   bram_sdp_stream_reader #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .RD_LATENCY(2), .FIFO_DEPTH(4)) u_dut_l2 (
      .CLK(clk), .RST_N(rst_n), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready[1]),
      .CMD_ADDR(cmd_addr), .CMD_LEN(cmd_len), .RDADDR(rdaddr[1]), .RDEN(rden[1]),
      .DO(d2_s2), .M_VALID(m_valid[1]), .M_READY(m_ready), .M_DATA(m_data[1]),
      .M_LAST(m_last[1]), .BUSY(busy[1]));

   function automatic logic [31:0] word_at(input logic [8:0] a);
      return {7'h5A, a, 7'h33, a};
   endfunction

   // BRAM read port models: DO_REG=0 and DO_REG=1
   always @(posedge clk) begin
      if (rden[0]) d1_s1 <= word_at(rdaddr[0]);
      if (rden[1]) d2_s1 <= word_at(rdaddr[1]);
      d2_s2 <= d2_s1;
   end

   always @(posedge clk) begin
      #2;
      case (rmode)
         0:       m_ready = 1'b0;
         1:       m_ready = 1'b1;
         default: m_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Stream scoreboard, sampled mid-cycle
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (mon_en) begin
            if (rden[k]) rden_cnt[k]++;
            if (m_valid[k]) begin
               vld_cnt[k]++;
               if (first_v[k] < 0) first_v[k] = cyc;
            end
            if (pv[k] && !pr[k]) begin
               checks++;
               if (!m_valid[k] || m_data[k] !== pd[k] || m_last[k] !== pl[k]) begin
                  errors++;
                  $display("FAIL hold dut%0d: valid=%0b data=%h last=%0b, required valid=1 data=%h last=%0b",
                           k, m_valid[k], m_data[k], m_last[k], pd[k], pl[k]);
               end
            end
            if (m_valid[k] && m_ready) begin
               checks++;
               if (m_data[k] !== word_at(exp_addr[k])) begin
                  errors++;
                  $display("FAIL data dut%0d word %0d: got %h, expected %h", k, got[k], m_data[k],
                           word_at(exp_addr[k]));
               end
               checks++;
               if (m_last[k] !== (got[k] == cur_len - 1)) begin
                  errors++;
                  $display("FAIL last dut%0d word %0d: got %0b, expected %0b", k, got[k], m_last[k],
                           (got[k] == cur_len - 1));
               end
               if (m_last[k]) begin
                  last_cnt[k]++;
                  last_addr[k] = exp_addr[k];
               end
               last_hs[k] = cyc;
               exp_addr[k] = exp_addr[k] + 9'd1;
               got[k]++;
            end
         end
         pv[k] = m_valid[k];
         pr[k] = m_ready;
         pd[k] = m_data[k];
         pl[k] = m_last[k];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int k, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s dut%0d: got %0h, expected %0h", name, k, act, req);
      end
   endtask

   task automatic clr_sb(input logic [8:0] addr, input logic [9:0] len);
      cur_len = int'(len);
      for (int k = 0; k < 2; k++) begin
         exp_addr[k] = addr;
         got[k]      = 0;
         last_cnt[k] = 0;
         last_addr[k] = '0;
         rden_cnt[k] = 0;
         vld_cnt[k]  = 0;
         first_v[k]  = -1;
         last_hs[k]  = -1;
      end
   endtask

   task automatic issue_cmd(input logic [8:0] addr, input logic [9:0] len, output int n_acc);
      int t = 0;
      while (!(cmd_ready[0] && cmd_ready[1]) && t < 2000) begin
         step();
         t++;
      end
      if (t >= 2000) chk("idle_timeout", 0, t, 0);
      cmd_addr  = addr;
      cmd_len   = len;
      cmd_valid = 1'b1;
      step();
      n_acc     = cyc;
      cmd_valid = 1'b0;
      cmd_addr  = ~addr;
      cmd_len   = 10'd3;
   endtask

   task automatic wait_done(input int words, input int budget);
      int t = 0;
      while (!(got[0] >= words && got[1] >= words && !busy[0] && !busy[1]) && t < budget) begin
         step();
         t++;
      end
      if (t >= budget) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: waited %0d cycles, got %0d/%0d words, required %0d", t, got[0], got[1], words);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      int crlow = 0;
      rmode = v.mode;
      step();
      clr_sb(v.addr, v.len);
      mon_en = 1'b1;
      issue_cmd(v.addr, v.len, n);
      if (v.len != 0) begin
         step();
         for (int k = 0; k < 2; k++) begin
            chk("first_rden", k, rden[k], 1);
            chk("first_rdaddr", k, rdaddr[k], v.addr);
         end
         wait_done(v.words, 8 * v.words + 60);
      end else begin
         repeat (8) begin
            step();
            for (int k = 0; k < 2; k++) if (!cmd_ready[k] || busy[k]) crlow++;
         end
         chk("len0_ready", 0, crlow, 0);
      end
      step();
      step();
      for (int k = 0; k < 2; k++) begin
         chk("word_count", k, got[k], v.words);
         chk("read_count", k, rden_cnt[k], v.words);
         chk("last_count", k, last_cnt[k], (v.words > 0) ? 1 : 0);
         chk("idle_ready", k, cmd_ready[k], 1);
         if (v.words > 0) begin
            chk("last_addr", k, last_addr[k], v.last_addr);
            chk("first_valid_lat", k, first_v[k] - n, k + 3);
            if (v.mode == 1) chk("no_bubbles", k, last_hs[k] - first_v[k], v.words - 1);
         end else begin
            chk("len0_valid", k, vld_cnt[k], 0);
         end
      end
      mon_en = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int bad;
      vecs[0] = '{9'h010, 10'd4,   1, 4,   9'h013};
      vecs[1] = '{9'h1FE, 10'd4,   1, 4,   9'h001};
      vecs[2] = '{9'h055, 10'd0,   1, 0,   9'h000};
      vecs[3] = '{9'h000, 10'd512, 2, 512, 9'h1FF};
      vecs[4] = '{9'h0C3, 10'd512, 1, 512, 9'h0C2};
      vecs[5] = '{9'h1FF, 10'd1,   2, 1,   9'h1FF};
      vecs[6] = '{9'h100, 10'd7,   2, 7,   9'h106};

      // Reset values, then CMD_READY rises one edge after release
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("rst_ctrl", k, {cmd_ready[k], rden[k], m_valid[k], m_last[k], busy[k]}, 0);
         chk("rst_rdaddr", k, rdaddr[k], 0);
         chk("rst_mdata", k, m_data[k], 0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) chk("ready_before_edge", k, cmd_ready[k], 0);
      step();
      for (int k = 0; k < 2; k++) chk("ready_after_edge", k, cmd_ready[k], 1);

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Consumer stalled: credit stops reads at FIFO depth, head word held
      rmode = 0;
      step();
      clr_sb(9'h0A0, 10'd16);
      mon_en = 1'b1;
      issue_cmd(9'h0A0, 10'd16, n);
      repeat (20) step();
      for (int k = 0; k < 2; k++) begin
         chk("stall_reads", k, rden_cnt[k], 4);
         chk("stall_rden", k, rden[k], 0);
         chk("stall_valid", k, m_valid[k], 1);
         chk("stall_head", k, m_data[k], word_at(9'h0A0));
         chk("stall_busy", k, busy[k], 1);
      end
      rmode = 1;
      wait_done(16, 200);
      for (int k = 0; k < 2; k++) begin
         chk("stall_words", k, got[k], 16);
         chk("stall_last_cnt", k, last_cnt[k], 1);
         chk("stall_last_addr", k, last_addr[k], 9'h0AF);
      end
      mon_en = 1'b0;

      // Reset mid-burst after three words
      rmode = 1;
      step();
      clr_sb(9'h020, 10'd8);
      mon_en = 1'b1;
      issue_cmd(9'h020, 10'd8, n);
      bad = 0;
      while (got[0] < 3 && bad < 50) begin
         step();
         bad++;
      end
      chk("midrst_progress", 0, got[0] >= 3, 1);
      mon_en = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("midrst_ctrl", k, {cmd_ready[k], rden[k], m_valid[k], m_last[k], busy[k]}, 0);
         chk("midrst_rdaddr", k, rdaddr[k], 0);
         chk("midrst_mdata", k, m_data[k], 0);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      bad = 0;
      repeat (10) begin
         step();
         for (int k = 0; k < 2; k++)
            if (!cmd_ready[k] || m_valid[k] || rden[k] || busy[k]) bad++;
      end
      chk("postrst_quiet", 0, bad, 0);

      run_vec(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
